// File: rtl/boot_loader.sv
// Byte-stream boot loader feeding the cpu instruction-memory initialize port.
// Stream format: 16-bit little-endian word count N, then N little-endian 32-bit words.
// Word i is presented at byte address 4*i for HOLD_CYCLES cycles while the cpu is held in reset.
// Optional macro BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte over the payload.
module boot_loader #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned MAX_WORDS   = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        cpu_rst,
   output logic        initialize,
   output logic [31:0] instruction_initialize_data,
   output logic [31:0] instruction_initialize_address,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned WW = $clog2(MAX_WORDS + 1);
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef BOOT_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      StIdle, StHdrLo, StHdrHi, StData, StWrite, StDone, StError, StCsum
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StHdrLo, StHdrHi, StData, StWrite, StDone, StError
   } state_e;
`endif

   state_e        state_q, state_d;
   logic [15:0]   n_q, n_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   addr_q, addr_d;
   logic [WW-1:0] word_q, word_d;
   logic [1:0]    byte_q, byte_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [7:0]    csum_q, csum_d;

   logic          xfer;
   logic [15:0]   n_full;
   logic [WW-1:0] word_inc;

   assign xfer     = in_valid & in_ready;
   assign n_full   = {in_data, n_q[7:0]};
   assign word_inc = word_q + WW'(1);

   // State and datapath registers; async reset returns everything to the idle/reset values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         n_q     <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         word_q  <= '0;
         byte_q  <= '0;
         hold_q  <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         hold_q  <= hold_d;
         csum_q  <= csum_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      data_d  = data_q;
      addr_d  = addr_q;
      word_d  = word_q;
      byte_d  = byte_q;
      hold_d  = hold_q;
      csum_d  = csum_q;
      case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d = StHdrLo;
               csum_d  = '0;
            end
         end
         StHdrLo: begin
            if (xfer) begin
               n_d[7:0] = in_data;
               state_d  = StHdrHi;
            end
         end
         StHdrHi: begin
            if (xfer) begin
               n_d = n_full;
               if (n_full == 16'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                  state_d = StCsum;
`else
                  state_d = StDone;
`endif
               end else if (32'(n_full) > MAX_WORDS) begin
                  state_d = StError;
               end else begin
                  state_d = StData;
                  word_d  = '0;
                  byte_d  = '0;
               end
            end
         end
         StData: begin
            if (xfer) begin
               // Bytes land little-endian directly in the visible data register.
               data_d[{byte_q, 3'b000} +: 8] = in_data;
               csum_d = csum_q ^ in_data;
               if (byte_q == 2'd3) begin
                  state_d = StWrite;
                  addr_d  = 32'({word_q, 2'b00});
                  hold_d  = '0;
                  byte_d  = '0;
               end else begin
                  byte_d = byte_q + 2'd1;
               end
            end
         end
         StWrite: begin
            if (hold_q == HW'(HOLD_CYCLES - 1)) begin
               word_d = word_inc;
               if (32'(word_inc) == 32'(n_q)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                  state_d = StCsum;
`else
                  state_d = StDone;
`endif
               end else begin
                  state_d = StData;
               end
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         StCsum: begin
            if (xfer) begin
               state_d = (in_data == csum_q) ? StDone : StError;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the registered state; cpu is released only while in DONE.
   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      cpu_rst    = 1'b1;
      initialize = 1'b1;
      case (state_q)
         StHdrLo, StHdrHi, StData: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         StWrite: busy = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
         StCsum: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
`endif
         StDone: begin
            done       = 1'b1;
            cpu_rst    = 1'b0;
            initialize = 1'b0;
         end
         StError: error = 1'b1;
         default: ;
      endcase
   end

   assign instruction_initialize_data    = data_q;
   assign instruction_initialize_address = addr_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus pushes expected writes, a monitor pops and
// compares each observed write (address, data, hold length, stability).
module tb_boot_loader;

   localparam int unsigned HOLD = 2;

   typedef logic [7:0] byte_list_t[$];
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, cpu_rst, initialize, busy, done, error;
   logic [31:0] ini_data, ini_addr;

   int errors = 0;
   int checks = 0;
   wr_t exp_q[$];

   boot_loader #(
      .HOLD_CYCLES(HOLD),
      .MAX_WORDS  (256)
   ) dut (
      .clk                           (clk),
      .rst                           (rst),
      .start                         (start),
      .in_data                       (in_data),
      .in_valid                      (in_valid),
      .in_ready                      (in_ready),
      .cpu_rst                       (cpu_rst),
      .initialize                    (initialize),
      .instruction_initialize_data   (ini_data),
      .instruction_initialize_address(ini_addr),
      .busy                          (busy),
      .done                          (done),
      .error                         (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a write is visible while busy with in_ready low.
   int          run_len = 0;
   logic [31:0] run_addr, run_data;
   bit          run_unstable;
   always @(negedge clk) begin
      if (busy && !in_ready) begin
         if (run_len == 0) begin
            run_addr     = ini_addr;
            run_data     = ini_data;
            run_unstable = 1'b0;
         end else if (ini_addr !== run_addr || ini_data !== run_data) begin
            run_unstable = 1'b1;
         end
         run_len++;
      end else if (run_len != 0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                     run_addr, run_data);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("write_addr", run_addr, w.addr);
            check("write_data", run_data, w.data);
            check("write_hold_len", 32'(run_len), 32'(HOLD));
            check("write_stable", 32'(run_unstable), 32'd0);
         end
         run_len = 0;
      end
   end

   task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (gap) @(negedge clk);
   endtask

   task automatic send_list(input byte_list_t bs, input bit gap);
      foreach (bs[i]) send_byte(bs[i], gap);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || error) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("end_timeout", 32'(n < 100), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
      check({tag, "_initialize"}, 32'(initialize), 32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_data"}, ini_data, 32'h0);
      check({tag, "_addr"}, ini_addr, 32'h0);
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
      check({tag, "_initialize"}, 32'(initialize), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic check_error(input string tag);
      check({tag, "_error"}, 32'(error), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
      check({tag, "_initialize"}, 32'(initialize), 32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   // Two-word program with its payload XOR (0x3F) appended when the checksum is built in.
   task automatic load_two(input bit gap);
      expect_write(32'd0, 32'h2028_0005);
      expect_write(32'd4, 32'h0002_1020);
      send_list('{8'h02, 8'h00, 8'h05, 8'h00, 8'h28, 8'h20, 8'h20, 8'h10, 8'h02, 8'h00}, gap);
`ifdef BOOT_LOADER_CHECKSUM_EN
      send_byte(8'h3F, gap);
`endif
      wait_end();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check_reset_vals("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check_reset_vals("idle20");

      // Back-to-back load.
      pulse_start();
      check("startA_busy", 32'(busy), 32'd1);
      load_two(1'b0);
      check_done("loadA");
      check("loadA_addr_kept", ini_addr, 32'd4);
      check("loadA_data_kept", ini_data, 32'h0002_1020);

      // Restart from DONE with gapped valid; cpu goes back into reset immediately.
      pulse_start();
      check("startB_cpu_rst", 32'(cpu_rst), 32'd1);
      check("startB_initialize", 32'(initialize), 32'd1);
      load_two(1'b1);
      check_done("loadB");

      // Oversized count is a protocol error; a following empty load succeeds.
      pulse_start();
      send_list('{8'h01, 8'h01}, 1'b0);
      wait_end();
      check_error("n257");
      pulse_start();
      send_list('{8'h00, 8'h00}, 1'b0);
`ifdef BOOT_LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0);
`endif
      wait_end();
      check_done("n0");

      // Reset in the middle of the third word of a four-word load.
      pulse_start();
      expect_write(32'd0, 32'h0403_0201);
      expect_write(32'd4, 32'h0807_0605);
      send_list('{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h09, 8'h0A}, 1'b0);
      check("pre_abort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_vals("abort");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse_start();
      expect_write(32'd0, 32'hDDCC_BBAA);
      send_list('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
`ifdef BOOT_LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0);
`endif
      wait_end();
      check_done("after_abort");

`ifdef BOOT_LOADER_CHECKSUM_EN
      // Payload 11 22 33 44 XORs to 0x44.
      pulse_start();
      expect_write(32'd0, 32'h4433_2211);
      send_list('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 1'b0);
      wait_end();
      check_done("csum_good");
      pulse_start();
      expect_write(32'd0, 32'h4433_2211);
      send_list('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 1'b0);
      wait_end();
      check_error("csum_bad");
`endif

      repeat (4) @(negedge clk);
      check("writes_outstanding", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
